tcb_lite_lib_sub_sram: RTL



---
 rtl/tcb_lite_lib_sub_sram.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/tcb_lite_lib_sub_sram.sv
// TCB-Lite subordinate backed by an on-chip byte-lane SRAM array.
// Accepts one request per handshake, optionally stretches the handshake with
// wait states, and returns {rdt, err} a fixed DLY cycles after each transfer.
module tcb_lite_lib_sub_sram #(
    parameter int unsigned DLY  = 1,     // response delay, 1..4
    parameter int unsigned HLD  = 1,     // 1: hold last response, 0: zero between responses
    parameter int unsigned MOD  = 1,     // 0: logarithmic size, 1: byte enables
    parameter int unsigned CTL  = 1,
    parameter int unsigned ADR  = 32,
    parameter int unsigned DAT  = 32,
    parameter int unsigned STS  = 1,
    parameter int unsigned SIZE = 4096,  // bytes, power of two
    parameter int unsigned WST  = 0,     // wait states per request
    localparam int unsigned BYT = DAT / 8,
    localparam int unsigned SIZ = ($clog2($clog2(BYT) + 1) > 0) ? $clog2($clog2(BYT) + 1) : 1
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           vld,
    output logic           rdy,
    input  logic           lck,
    input  logic           ndn,
    input  logic           wen,
    input  logic [CTL-1:0] ctl,
    input  logic [ADR-1:0] adr,
    input  logic [SIZ-1:0] siz,
    input  logic [BYT-1:0] byt,
    input  logic [DAT-1:0] wdt,
    output logic [DAT-1:0] rdt,
    output logic [STS-1:0] sts,
    output logic           err
);

    localparam int unsigned OFFB  = $clog2(BYT);
    localparam int unsigned OFFW  = (OFFB > 0) ? OFFB : 1;
    localparam int unsigned MEMB  = $clog2(SIZE);
    localparam int unsigned DEPTH = SIZE / BYT;
    localparam int unsigned WCW   = (WST > 1) ? $clog2(WST) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ACK
    } state_t;

    logic                       trn;
    logic [MEMB-OFFB-1:0]       idx;
    logic [OFFW-1:0]            off;
    logic [BYT-1:0]             lane_en;
    int                         lane_src [BYT];
    int                         win;
    logic                       rng_err;
    logic                       fmt_err;
    logic                       req_err;
    logic [DAT-1:0]             rd_word;
    logic [DAT-1:0]             rd_lanes;
    logic [DAT-1:0]             wr_word;
    logic [DAT-1:0]             rsp_rdt;

    logic [DAT-1:0]             mem [DEPTH];

    logic [DLY-1:0]             dvld_q;
    logic [DLY-1:0][DAT-1:0]    drdt_q;
    logic [DLY-1:0]             derr_q;
    logic [DLY:0]               vld_chain;
    logic [DLY:0][DAT-1:0]      rdt_chain;
    logic [DLY:0]               err_chain;

    assign trn = vld & rdy;
    assign idx = adr[MEMB-1:OFFB];

    generate
        if (OFFB > 0) begin : g_off
            assign off = adr[OFFB-1:0];
        end else begin : g_no_off
            assign off = '0;
        end
    endgenerate

    // ------------------------------------------------------------------
    // Handshake: either always ready, or a wait-state FSM gating rdy.
    // ------------------------------------------------------------------
    generate
        if (WST == 0) begin : g_no_wait
            logic rdy_q;

            // Ready rises on the first edge after reset release and stays high.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) rdy_q <= 1'b0;
                else      rdy_q <= 1'b1;
            end

            assign rdy = rdy_q;
        end else begin : g_wait
            state_t         state_q, state_d;
            logic [WCW-1:0] wcnt_q, wcnt_d;

            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge value of every other register.
            // State register and wait counter.
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    state_q <= ST_IDLE;
                    wcnt_q  <= '0;
                end else begin
                    state_q <= state_d;
                    wcnt_q  <= wcnt_d;
                end
            end

            // NOTE: defaults first so no path through this block infers a latch.
            // Next-state logic; a held request in ACK restarts the wait sequence.
            always_comb begin
                state_d = state_q;
                wcnt_d  = wcnt_q;
                case (state_q)
                    ST_IDLE: begin
                        if (vld) begin
                            state_d = ST_WAIT;
                            wcnt_d  = WCW'(WST - 1);
                        end
                    end
                    ST_WAIT: begin
                        if (wcnt_q == '0) state_d = ST_ACK;
                        else              wcnt_d  = wcnt_q - 1'b1;
                    end
                    ST_ACK: begin
                        if (vld) begin
                            state_d = ST_WAIT;
                            wcnt_d  = WCW'(WST - 1);
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end
                    default: state_d = ST_IDLE;
                endcase
            end

            assign rdy = (state_q == ST_ACK);
        end
    endgenerate

    // Request decode: enabled lanes, per-lane source lane and error flags.
    always_comb begin
        rng_err = (64'(adr) >= 64'(SIZE));
        fmt_err = 1'b0;
        lane_en = '0;
        win     = 1;
        for (int i = 0; i < int'(BYT); i++) lane_src[i] = i;
        if (MOD == 0) begin
            win     = 1 << siz;
            fmt_err = (int'(siz) > int'(OFFB)) || ((int'(off) & (win - 1)) != 0);
            for (int i = 0; i < int'(BYT); i++) begin
                if ((i >= int'(off)) && (i < int'(off) + win)) begin
                    lane_en[i] = 1'b1;
                    // big-endian mirrors lanes inside the transfer window
                    if (ndn && !fmt_err) lane_src[i] = 2 * int'(off) + win - 1 - i;
                end
            end
        end else begin
            lane_en = byt;
        end
        req_err = rng_err | fmt_err;
    end

    // Lane steering for write data and read data; disabled lanes read as 0.
    always_comb begin
        rd_word  = mem[idx];
        rd_lanes = '0;
        wr_word  = '0;
        for (int i = 0; i < int'(BYT); i++) begin
            wr_word[8*i +: 8] = wdt[8*lane_src[i] +: 8];
            if (lane_en[i]) rd_lanes[8*i +: 8] = rd_word[8*lane_src[i] +: 8];
        end
        rsp_rdt = (wen || req_err) ? '0 : rd_lanes;
    end

    // NOTE: the array carries no reset; its contents are undefined until written.
    // Byte-lane write on an accepted, error-free write transfer.
    always_ff @(posedge clk) begin
        if (trn && wen && !req_err) begin
            for (int i = 0; i < int'(BYT); i++) begin
                if (lane_en[i]) mem[idx][8*i +: 8] <= wr_word[8*i +: 8];
            end
        end
    end

    // ------------------------------------------------------------------
    // Response delay line: stage 0 captures at the transfer edge, the last
    // stage drives the bus. Data only advances with a valid token, so the
    // last stage keeps the previous response when HLD=1.
    // ------------------------------------------------------------------
    assign vld_chain = {dvld_q, trn};
    assign rdt_chain = {drdt_q, rsp_rdt};
    assign err_chain = {derr_q, req_err};

    // Shift the response tokens; reset drops anything in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            dvld_q <= '0;
            drdt_q <= '0;
            derr_q <= '0;
        end else begin
            for (int s = 0; s < int'(DLY); s++) begin
                dvld_q[s] <= vld_chain[s];
                if (vld_chain[s]) begin
                    drdt_q[s] <= rdt_chain[s];
                    derr_q[s] <= err_chain[s];
                end else if (HLD == 0) begin
                    drdt_q[s] <= '0;
                    derr_q[s] <= 1'b0;
                end
            end
        end
    end

    assign rdt = drdt_q[DLY-1];
    assign err = derr_q[DLY-1];
    assign sts = '0;

    logic unused_ok;
    assign unused_ok = ^{lck, ctl, siz, byt, vld_chain[DLY]};

endmodule
